icache_blocking: RTL and testbench

// - Direct-mapped, blocking instruction cache serving the core's instruction fetch port (IBus side).
// - Fetch returns one 32-bit word per request; misses refill a whole line over a burst read port.
// - Uncached fetches issue a single-beat read, bypass the arrays and are not retained.
// - Line invalidate-all walks the sets.

---
 rtl/icache_blocking_pkg.sv | 32 +++
 rtl/icache_line_ram.sv | 68 ++++++
 rtl/icache_blocking.sv | 205 ++++++++++++++++++++
 tb/tb_icache_blocking.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_blocking_pkg.sv
// icache_blocking_pkg
// Shared definitions for the blocking instruction cache:
//   - cache geometry (ICACHE_SETS lines of ICACHE_LINE_WORDS 32-bit words)
//   - derived field widths of a fetch address (OFFSET_W, INDEX_W, TAG_W)
//   - icache_state_t, the controller state encoding
//   - icache_addr_t, a fetch address split into tag / index / word offset / byte bits
package icache_blocking_pkg;

    localparam int ICACHE_SETS       = 64;
    localparam int ICACHE_LINE_WORDS = 4;

    localparam int OFFSET_W = $clog2(ICACHE_LINE_WORDS);
    localparam int INDEX_W  = $clog2(ICACHE_SETS);
    localparam int TAG_W    = 32 - INDEX_W - OFFSET_W - 2;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS,
        REFILL,
        RESP,
        INVAL
    } icache_state_t;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
        logic [1:0]          byte_off;
    } icache_addr_t;

endpackage

// File: rtl/icache_line_ram.sv
// icache_line_ram
// Storage for the direct-mapped instruction cache: one tag, one valid bit and
// ICACHE_LINE_WORDS data words per set.
// Ports:
//   clk, reset                 clock and synchronous active-low reset (clears valid bits only)
//   rd_index, rd_offset        combinational read address
//   rd_tag, rd_valid, rd_word  tag, valid bit and selected word of the addressed set
//   word_we, wr_index,
//   wr_offset, wr_data         write one data word
//   tag_we, wr_tag             write the tag of set wr_index and mark it valid
//   clr_en, clr_index          clear a single valid bit
module icache_line_ram
    import icache_blocking_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic [TAG_W-1:0]    rd_tag,
    output logic                rd_valid,
    output logic [31:0]         rd_word,
    input  logic                word_we,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [31:0]         wr_data,
    input  logic                tag_we,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic                clr_en,
    input  logic [INDEX_W-1:0]  clr_index
);

    logic [TAG_W-1:0]       tag_mem  [ICACHE_SETS];
    logic [31:0]            data_mem [ICACHE_SETS*ICACHE_LINE_WORDS];
    logic [ICACHE_SETS-1:0] valid;

    // Reads are purely combinational so the controller can decide hit/miss in
    // the same cycle the set index is presented.
    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid[rd_index];
    assign rd_word  = data_mem[{rd_index, rd_offset}];

    // Tag and data arrays carry no reset: their contents are meaningless until
    // the matching valid bit is set, which keeps them mappable onto RAM.
    always_ff @(posedge clk) begin
        if (word_we) begin
            data_mem[{wr_index, wr_offset}] <= wr_data;
        end
        if (tag_we) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    // Valid bits are real flops so reset can wipe the whole cache in one cycle.
    // A line becomes valid only when its tag is written at the end of a refill.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= '0;
        end else begin
            if (tag_we) begin
                valid[wr_index] <= 1'b1;
            end
            if (clr_en) begin
                valid[clr_index] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/icache_blocking.sv
// icache_blocking
// Direct-mapped, blocking instruction cache. One fetch is serviced at a time;
// hits return one cycle after acceptance and may be pipelined back to back,
// misses refill a whole line with a burst read, uncached fetches issue a
// single-beat read that is returned but not stored.
// Ports:
//   clk, reset                       clock, synchronous active-low reset
//   cpu_req, cpu_addr, cpu_cached    fetch request, word address, cacheable flag
//   cpu_addr_ok                      request accepted this cycle
//   cpu_data_ok, cpu_rdata           fetched instruction valid / value
//   inv_all                          pulse: invalidate every line
//   mem_rd_req, mem_rd_addr,
//   mem_rd_len, mem_rd_rdy           burst read request handshake (len = beats-1)
//   mem_ret_valid, mem_ret_last,
//   mem_ret_data                     returned read beats
module icache_blocking
    import icache_blocking_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_cached,
    output logic        cpu_addr_ok,
    output logic        cpu_data_ok,
    output logic [31:0] cpu_rdata,
    input  logic        inv_all,
    output logic        mem_rd_req,
    output logic [31:0] mem_rd_addr,
    output logic [7:0]  mem_rd_len,
    input  logic        mem_rd_rdy,
    input  logic        mem_ret_valid,
    input  logic        mem_ret_last,
    input  logic [31:0] mem_ret_data
);

    icache_state_t       state, next_state;
    icache_addr_t        req_addr;
    logic                req_cached;
    logic                inv_pending;
    logic [OFFSET_W-1:0] beat_cnt;
    logic [INDEX_W-1:0]  inv_cnt;
    logic [31:0]         resp_data;

    logic                accept;
    logic                hit;
    logic                inv_block;
    logic                beat_we;
    logic                capture_beat;
    logic [OFFSET_W-1:0] last_beat;
    logic [TAG_W-1:0]    rd_tag;
    logic                rd_valid;
    logic [31:0]         rd_word;

    // The byte-select bits of a word address carry no information for fetches.
    logic unused_byte_bits;
    assign unused_byte_bits = ^cpu_addr[1:0];

    icache_line_ram u_line_ram (
        .clk       (clk),
        .reset     (reset),
        .rd_index  (req_addr.index),
        .rd_offset (req_addr.offset),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_word   (rd_word),
        .word_we   (beat_we),
        .wr_index  (req_addr.index),
        .wr_offset (beat_cnt),
        .wr_data   (mem_ret_data),
        .tag_we    (beat_we && mem_ret_last),
        .wr_tag    (req_addr.tag),
        .clr_en    (state == INVAL),
        .clr_index (inv_cnt)
    );

    assign hit          = req_cached && rd_valid && (rd_tag == req_addr.tag);
    assign inv_block    = inv_all || inv_pending;
    assign beat_we      = (state == REFILL) && mem_ret_valid && req_cached;
    assign capture_beat = req_cached ? (beat_cnt == req_addr.offset) : (beat_cnt == '0);
    assign last_beat    = req_cached ? OFFSET_W'(ICACHE_LINE_WORDS - 1) : '0;

    // Next-state and output decode. Every output defaults to zero and is only
    // raised by the state that owns it; holding reset low forces all of them
    // back to zero so nothing leaks out while the controller is being reset.
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        cpu_addr_ok = 1'b0;
        cpu_data_ok = 1'b0;
        cpu_rdata   = '0;
        mem_rd_req  = 1'b0;
        mem_rd_addr = '0;
        mem_rd_len  = '0;
        case (state)
            IDLE: begin
                if (inv_block) begin
                    next_state = INVAL;
                end else begin
                    cpu_addr_ok = 1'b1;
                    if (cpu_req) begin
                        accept     = 1'b1;
                        next_state = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                if (hit) begin
                    cpu_data_ok = 1'b1;
                    cpu_rdata   = rd_word;
                    if (!inv_block) begin
                        cpu_addr_ok = 1'b1;
                        accept      = cpu_req;
                    end
                    next_state = accept ? LOOKUP : IDLE;
                end else begin
                    next_state = MISS;
                end
            end
            MISS: begin
                mem_rd_req  = 1'b1;
                mem_rd_addr = req_cached ? {req_addr.tag, req_addr.index, {OFFSET_W{1'b0}}, 2'b00}
                                         : req_addr;
                mem_rd_len  = req_cached ? 8'(ICACHE_LINE_WORDS - 1) : 8'd0;
                if (mem_rd_rdy) begin
                    next_state = REFILL;
                end
            end
            REFILL: begin
                if (mem_ret_valid && mem_ret_last) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                cpu_data_ok = 1'b1;
                cpu_rdata   = resp_data;
                next_state  = IDLE;
            end
            INVAL: begin
                if (inv_cnt == INDEX_W'(ICACHE_SETS - 1)) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (!reset) begin
            accept      = 1'b0;
            cpu_addr_ok = 1'b0;
            cpu_data_ok = 1'b0;
            cpu_rdata   = '0;
            mem_rd_req  = 1'b0;
            mem_rd_addr = '0;
            mem_rd_len  = '0;
        end
    end

    // Controller state, request latch and counters. The beat counter restarts
    // when memory accepts the burst and simply wraps; the word whose position
    // matches the requested offset (beat 0 for uncached) becomes the response.
    // An invalidate that arrives while a fetch is in flight is remembered in
    // inv_pending and serviced once the controller is back in IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            req_addr    <= '0;
            req_cached  <= 1'b0;
            inv_pending <= 1'b0;
            beat_cnt    <= '0;
            inv_cnt     <= '0;
            resp_data   <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                req_addr   <= {cpu_addr[31:2], 2'b00};
                req_cached <= cpu_cached;
            end
            if (state == MISS && mem_rd_rdy) begin
                beat_cnt <= '0;
            end else if (state == REFILL && mem_ret_valid) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (state == REFILL && mem_ret_valid && capture_beat) begin
                resp_data <= mem_ret_data;
            end
            if (next_state == INVAL && state != INVAL) begin
                inv_pending <= 1'b0;
                inv_cnt     <= '0;
            end else begin
                if (inv_all && (state == LOOKUP || state == MISS || state == REFILL || state == RESP)) begin
                    inv_pending <= 1'b1;
                end
                if (state == INVAL) begin
                    inv_cnt <= inv_cnt + 1'b1;
                end
            end
        end
    end

    // A burst must end exactly on the beat implied by the requested length.
    assert property (@(posedge clk) disable iff (!reset)
        (state == REFILL && mem_ret_valid && mem_ret_last) |-> (beat_cnt == last_beat));

endmodule

// File: tb/tb_icache_blocking.sv
// tb_icache_blocking
// Directed bench for icache_blocking. The bench plays both the core and the
// memory side; every expected value is written out by hand in the stimulus.
// Inputs change on the falling edge and outputs are sampled just after it.
module tb_icache_blocking;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_cached;
    logic        cpu_addr_ok;
    logic        cpu_data_ok;
    logic [31:0] cpu_rdata;
    logic        inv_all;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic [7:0]  mem_rd_len;
    logic        mem_rd_rdy;
    logic        mem_ret_valid;
    logic        mem_ret_last;
    logic [31:0] mem_ret_data;

    int vectors     = 0;
    int miscompares = 0;

    icache_blocking dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_req       (cpu_req),
        .cpu_addr      (cpu_addr),
        .cpu_cached    (cpu_cached),
        .cpu_addr_ok   (cpu_addr_ok),
        .cpu_data_ok   (cpu_data_ok),
        .cpu_rdata     (cpu_rdata),
        .inv_all       (inv_all),
        .mem_rd_req    (mem_rd_req),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_len    (mem_rd_len),
        .mem_rd_rdy    (mem_rd_rdy),
        .mem_ret_valid (mem_ret_valid),
        .mem_ret_last  (mem_ret_last),
        .mem_ret_data  (mem_ret_data)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a wedged design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the end of stimulus");
        $fatal(1, "[TB] watchdog");
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive the core-side request inputs.
    task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic cached);
        cpu_req    = req;
        cpu_addr   = addr;
        cpu_cached = cached;
    endtask

    // Fetch expected to hit: accepted in one cycle, data the next cycle.
    task automatic fetchHit(input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        applyStimulus(1'b1, addr, 1'b1);
        #1 checkOutput("hit_addr_ok", cpu_addr_ok, 1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("hit_data_ok", cpu_data_ok, 1);
        checkOutput("hit_rdata", cpu_rdata, exp);
        checkOutput("hit_no_mem_req", mem_rd_req, 0);
    endtask

    // Fetch expected to miss: checks the read request (optionally stalling
    // mem_rd_rdy), returns nbeats words base+0, base+1, ... and checks the
    // single response pulse. pulse_inv raises inv_all during the first beat.
    task automatic fetchMiss(input logic [31:0] addr, input logic cached,
                             input logic [31:0] exp_mem_addr, input logic [7:0] exp_len,
                             input logic [31:0] base, input int nbeats, input int stall,
                             input logic pulse_inv, input logic [31:0] exp_rdata);
        int waited;
        @(negedge clk);
        applyStimulus(1'b1, addr, cached);
        #1 checkOutput("miss_addr_ok", cpu_addr_ok, 1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b1);
        #1 checkOutput("miss_no_early_data", cpu_data_ok, 0);
        waited = 0;
        while (!mem_rd_req && waited < 8) begin
            @(negedge clk);
            #1 waited++;
        end
        checkOutput("miss_rd_req", mem_rd_req, 1);
        checkOutput("miss_rd_addr", mem_rd_addr, exp_mem_addr);
        checkOutput("miss_rd_len", {24'h0, mem_rd_len}, {24'h0, exp_len});
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            #1;
            checkOutput("stall_rd_req", mem_rd_req, 1);
            checkOutput("stall_rd_addr", mem_rd_addr, exp_mem_addr);
            checkOutput("stall_rd_len", {24'h0, mem_rd_len}, {24'h0, exp_len});
        end
        mem_rd_rdy = 1'b1;
        @(negedge clk);
        mem_rd_rdy = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            mem_ret_valid = 1'b1;
            mem_ret_data  = base + 32'(b);
            mem_ret_last  = (b == nbeats - 1);
            inv_all       = pulse_inv && (b == 0);
            @(negedge clk);
        end
        mem_ret_valid = 1'b0;
        mem_ret_last  = 1'b0;
        inv_all       = 1'b0;
        #1;
        checkOutput("miss_data_ok", cpu_data_ok, 1);
        checkOutput("miss_rdata", cpu_rdata, exp_rdata);
        @(negedge clk);
        #1 checkOutput("miss_single_pulse", cpu_data_ok, 0);
    endtask

    // Count consecutive cycles with cpu_addr_ok low, starting in the current
    // cycle; inv_all is dropped after the first counted cycle.
    task automatic countBlocked(input string tag, input int exp_cycles);
        int   blocked = 0;
        logic done    = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            #1;
            if (cpu_addr_ok) begin
                done = 1'b1;
            end else begin
                blocked++;
                @(negedge clk);
                inv_all = 1'b0;
            end
        end
        checkOutput(tag, 32'(blocked), 32'(exp_cycles));
    endtask

    initial begin
        reset         = 1'b0;
        inv_all       = 1'b0;
        mem_rd_rdy    = 1'b0;
        mem_ret_valid = 1'b0;
        mem_ret_last  = 1'b0;
        mem_ret_data  = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b1);

        // Reset: every output quiet while reset is held, then ready in IDLE.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_addr_ok", cpu_addr_ok, 0);
        checkOutput("rst_data_ok", cpu_data_ok, 0);
        checkOutput("rst_rdata", cpu_rdata, 0);
        checkOutput("rst_rd_req", mem_rd_req, 0);
        checkOutput("rst_rd_addr", mem_rd_addr, 0);
        checkOutput("rst_rd_len", {24'h0, mem_rd_len}, 0);
        @(negedge clk);
        reset = 1'b1;
        #1 checkOutput("idle_addr_ok", cpu_addr_ok, 1);

        // Cold miss on 0x1000: line address 0x1000, 4 beats, word 0 returned.
        fetchMiss(32'h0000_1000, 1'b1, 32'h0000_1000, 8'd3, 32'hA000_0000, 4, 0, 1'b0, 32'hA000_0000);

        // Back-to-back hits 0x1004, 0x1008: data on the two following cycles.
        @(negedge clk);
        applyStimulus(1'b1, 32'h0000_1004, 1'b1);
        #1 checkOutput("b2b_accept0", cpu_addr_ok, 1);
        @(negedge clk);
        applyStimulus(1'b1, 32'h0000_1008, 1'b1);
        #1;
        checkOutput("b2b_data_ok0", cpu_data_ok, 1);
        checkOutput("b2b_rdata0", cpu_rdata, 32'hA000_0001);
        checkOutput("b2b_accept1", cpu_addr_ok, 1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("b2b_data_ok1", cpu_data_ok, 1);
        checkOutput("b2b_rdata1", cpu_rdata, 32'hA000_0002);
        checkOutput("b2b_no_mem_req", mem_rd_req, 0);
        @(negedge clk);
        #1 checkOutput("b2b_done", cpu_data_ok, 0);

        // Uncached fetches: exact address, length 0, never retained.
        fetchMiss(32'hBFC0_0000, 1'b0, 32'hBFC0_0000, 8'd0, 32'h3C1D_0000, 1, 0, 1'b0, 32'h3C1D_0000);
        fetchMiss(32'hBFC0_0000, 1'b0, 32'hBFC0_0000, 8'd0, 32'h2408_0000, 1, 0, 1'b0, 32'h2408_0000);
        fetchHit(32'h0000_1000, 32'hA000_0000);

        // Conflict on set 0: 0x1400 evicts 0x1000, which then misses again.
        fetchMiss(32'h0000_1400, 1'b1, 32'h0000_1400, 8'd3, 32'hB000_0000, 4, 0, 1'b0, 32'hB000_0000);
        fetchMiss(32'h0000_1000, 1'b1, 32'h0000_1000, 8'd3, 32'hA100_0000, 4, 0, 1'b0, 32'hA100_0000);

        // Critical word: 0x200C returns the fourth beat; the line then hits.
        fetchMiss(32'h0000_200C, 1'b1, 32'h0000_2000, 8'd3, 32'hC0DE_0000, 4, 0, 1'b0, 32'hC0DE_0003);
        fetchHit(32'h0000_2000, 32'hC0DE_0000);
        fetchHit(32'h0000_2008, 32'hC0DE_0002);

        // Invalidate from IDLE: the pulse cycle plus 64 walk cycles blocked.
        @(negedge clk);
        inv_all = 1'b1;
        countBlocked("inv_idle_blocked", 65);

        // Invalidate during a refill: fetch finishes, then the walk clears it.
        fetchMiss(32'h0000_2000, 1'b1, 32'h0000_2000, 8'd3, 32'hD000_0000, 4, 0, 1'b1, 32'hD000_0000);
        countBlocked("inv_pending_blocked", 65);

        // Stall: read request held stable 5 cycles; line was cleared so it misses.
        fetchMiss(32'h0000_2004, 1'b1, 32'h0000_2000, 8'd3, 32'hE000_0000, 4, 5, 1'b0, 32'hE000_0001);
        fetchHit(32'h0000_200C, 32'hE000_0003);

        // Reset in the middle of a refill of 0x1400.
        @(negedge clk);
        applyStimulus(1'b1, 32'h0000_1400, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        #1 checkOutput("rst_mid_rd_req", mem_rd_req, 1);
        mem_rd_rdy = 1'b1;
        @(negedge clk);
        mem_rd_rdy    = 1'b0;
        mem_ret_valid = 1'b1;
        mem_ret_data  = 32'hBAD0_0000;
        @(negedge clk);
        mem_ret_valid = 1'b0;
        reset         = 1'b0;
        #1;
        checkOutput("rst_mid_addr_ok", cpu_addr_ok, 0);
        checkOutput("rst_mid_rd_req_off", mem_rd_req, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("post_rst_addr_ok", cpu_addr_ok, 1);
        checkOutput("post_rst_data_ok", cpu_data_ok, 0);
        checkOutput("post_rst_rdata", cpu_rdata, 0);
        checkOutput("post_rst_rd_req", mem_rd_req, 0);
        checkOutput("post_rst_rd_addr", mem_rd_addr, 0);
        checkOutput("post_rst_rd_len", {24'h0, mem_rd_len}, 0);

        // The previously valid 0x2000 line must now miss.
        fetchMiss(32'h0000_2008, 1'b1, 32'h0000_2000, 8'd3, 32'hF000_0000, 4, 0, 1'b0, 32'hF000_0002);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
